funnel_dat_2_1: RTL and testbench
=================================

# funnel_dat_2_1

Transmit-side counterpart of the 2:1 lane defunnel. It accepts one 256-bit word (two 128-bit lanes) per transaction and serializes it onto a single 128-bit lane as one or two beats, selected by the config reduction bit. It sits on the initiator side of a narrow link and feeds the defunnel at the far end, which reassembles lanes in the same order. Flow control is req/ack on both sides, with full throughput and no bubbles between words.

## Interface
- `W`, 128: lane width in bits. The wide word is 2*W.
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `t_0_dat`  in  256: wide word. Lane0 = [127:0], lane1 = [255:128].
- `t_0_req`  in  1: upstream word valid.
- `t_0_ack`  out  1: block can take a word this cycle.
- `t_cfg_dat`  in  8: config. Only bit 0 (reduct) is used. 1 = 2:1 (two beats), 0 = 1:1 (lane0 only).
- `i_0_dat`  out  128: narrow beat data.
- `i_0_req`  out  1: beat valid.
- `i_0_ack`  in  1: downstream accepts the beat.
- `i_0_last`  out  1: current beat is the final beat of its word.
- `mode`  out  8: `t_cfg_dat` as captured with the word currently held.

## Operation
- Transfer rules:
  - Upstream transfer occurs when `t_0_req & t_0_ack`.
  - Downstream transfer occurs when `i_0_req & i_0_ack`.
- Accepting a word:
  - Capture `t_0_dat` into a 256-bit hold register.
  - Capture `t_cfg_dat` into `mode`.
  - Set `nbeats` = reduct ? 2 : 1.
  - Set phase = 0.
- State machine:
  - EMPTY: `i_0_req` = 0. A word is accepted and the state goes to BEAT0.
  - BEAT0: `i_0_dat` = lane0; `i_0_last` = (`nbeats` == 1). On ack, go to BEAT1 if `nbeats` == 2. Otherwise the word is done.
  - BEAT1: `i_0_dat` = lane1; `i_0_last` = 1. On ack the word is done.
  - Word done: go to BEAT0 if a new word is accepted in the same cycle, otherwise go to EMPTY.
- `t_0_ack` = (state == EMPTY) | (`i_0_last` & `i_0_ack`). This is combinational from registered state and `i_0_ack`, and enables back-to-back words.
- `t_0_ack` is forced to 0 while `reset_n` is low.
- Config changes take effect only at word acceptance. Changing `t_cfg_dat` while a word is held does not alter beat count or order.
- Lane1 is never emitted in 1:1 mode. Upper hold bits are ignored.
- While `i_0_req` = 1 and `i_0_ack` = 0: `i_0_dat`, `i_0_last` and `i_0_req` hold stable. No beat is dropped or reordered.
- Bits [7:1] of `t_cfg_dat` are carried on `mode` and otherwise ignored.

## Timing
- Reset values are applied at the first clk edge with `reset_n` = 0:
  - state = EMPTY, phase = 0
  - `i_0_req` = 0, `i_0_last` = 0
  - `i_0_dat` = 0, `mode` = 0
  - hold register = 0
- Latency: a word accepted at edge N presents lane0 with `i_0_req` = 1 in the cycle after N.
- Throughput with `i_0_ack` tied high:
  - 2:1 mode: one word per 2 cycles.
  - 1:1 mode: one word per cycle.
- Back-to-back: when the last beat is acked and a new word is accepted at the same edge, lane0 of the new word follows with no idle cycle.
- Reset mid-word: the held word is discarded, with no partial beat after reset. `t_0_ack` returns to 1 in the first cycle with `reset_n` = 1.
- Fixed beat order is lane0 then lane1, matching defunnel lane assignment (first beat → dat0, second → dat1).

## Structure
- Shared package `piston_funnel_pkg`:
  - lane width constant `W` = 128
  - `NLANES` = 2
  - state enum (EMPTY, BEAT0, BEAT1)
  - `CFG_REDUCT_BIT` = 0
- The defunnel uses the same package constants so both ends agree.
- Single flat module, no sub-module. It consists of a hold register, a 1-bit phase counter, and a lane mux.

## Test plan
- 2:1 mode, word {lane1=128'hB…B, lane0=128'hA…A}, `i_0_ack` = 1 → beats A, B. `i_0_last` = 0 then 1. `t_0_ack` = 0 during beat A.
- 1:1 mode, 3 words back-to-back, `i_0_ack` = 1 → 3 beats on 3 consecutive cycles, lane0 of each, all with `i_0_last` = 1. `t_0_ack` stays 1.
- 2:1 mode, `i_0_ack` low for 4 cycles during beat B → `i_0_dat` = B and `i_0_req` = 1 held stable. The next word is accepted only on the cycle B is acked.
- `t_cfg_dat` toggles 1→0 one cycle after acceptance of a 2:1 word → that word still emits 2 beats. The next word emits 1 beat.
- `reset_n` pulsed low while beat A is stalled → the first edge clears `i_0_req`/`i_0_dat`/`mode` to 0. B is never emitted. The next word starts cleanly at lane0.
- Loopback into `defunnel_dat_2_1` in 2:1 mode, random words and random ack stalls → reassembled 256-bit output equals the input sequence.

Source files
------------

// File: rtl/piston_funnel_pkg.sv
// Constants and state encoding shared by both ends of the 2:1 narrow link
// (the funnel here and the defunnel at the far end).
package piston_funnel_pkg;

   localparam int unsigned W              = 128;
   localparam int unsigned NLANES         = 2;
   localparam int unsigned CFG_REDUCT_BIT = 0;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2
   } state_e;

endpackage

// File: rtl/funnel_dat_2_1.sv
// 2:1 transmit funnel: holds one wide word and serializes it onto a single
// narrow lane as lane0 then (in reduct mode) lane1, with req/ack on both sides.
module funnel_dat_2_1
   import piston_funnel_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NLANES*W-1:0]   t_0_dat,
   input  logic                  t_0_req,
   output logic                  t_0_ack,
   input  logic [7:0]            t_cfg_dat,
   output logic [W-1:0]          i_0_dat,
   output logic                  i_0_req,
   input  logic                  i_0_ack,
   output logic                  i_0_last,
   output logic [7:0]            mode
);

   state_e                state_q, state_d;
   logic                  phase_q, phase_d;
   logic                  two_q, two_d;
   logic [NLANES*W-1:0]   hold_q, hold_d;
   logic [7:0]            mode_q, mode_d;
   logic                  accept;

   assign i_0_req  = (state_q != EMPTY);
   assign i_0_last = (state_q == BEAT1) | ((state_q == BEAT0) & ~two_q);
   assign i_0_dat  = phase_q ? hold_q[2*W-1:W] : hold_q[W-1:0];
   assign mode     = mode_q;

   // Ack in the same cycle the final beat leaves keeps words back-to-back.
   assign t_0_ack  = reset_n & ((state_q == EMPTY) | (i_0_last & i_0_ack));
   assign accept   = t_0_req & t_0_ack;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      two_d   = two_q;
      hold_d  = hold_q;
      mode_d  = mode_q;
      if (accept) begin
         hold_d  = t_0_dat;
         mode_d  = t_cfg_dat;
         two_d   = t_cfg_dat[CFG_REDUCT_BIT];
         phase_d = 1'b0;
         state_d = BEAT0;
      end else begin
         case (state_q)
            BEAT0: if (i_0_ack) begin
               if (two_q) begin
                  state_d = BEAT1;
                  phase_d = 1'b1;
               end else begin
                  state_d = EMPTY;
               end
            end
            BEAT1: if (i_0_ack) begin
               state_d = EMPTY;
               phase_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         phase_q <= 1'b0;
         two_q   <= 1'b0;
         hold_q  <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         two_q   <= two_d;
         hold_q  <= hold_d;
         mode_q  <= mode_d;
      end
   end

endmodule

// File: tb/tb_funnel_dat_2_1.sv
// Bench for funnel_dat_2_1: directed cycle table plus randomized traffic
// checked against a queue of expected beats.
module tb_funnel_dat_2_1;

   logic         clk;
   logic         reset_n;
   logic [255:0] t_0_dat;
   logic         t_0_req;
   logic         t_0_ack;
   logic [7:0]   t_cfg_dat;
   logic [127:0] i_0_dat;
   logic         i_0_req;
   logic         i_0_ack;
   logic         i_0_last;
   logic [7:0]   mode;

   int errors = 0;
   int checks = 0;

   funnel_dat_2_1 dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .t_0_dat   (t_0_dat),
      .t_0_req   (t_0_req),
      .t_0_ack   (t_0_ack),
      .t_cfg_dat (t_cfg_dat),
      .i_0_dat   (i_0_dat),
      .i_0_req   (i_0_req),
      .i_0_ack   (i_0_ack),
      .i_0_last  (i_0_last),
      .mode      (mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         rst_n;
      logic         treq;
      logic [255:0] tdat;
      logic [7:0]   cfg;
      logic         iack;
      logic         ereq;
      logic         elast;
      logic [127:0] edat;
      logic         chkdat;
      logic         etack;
      logic [7:0]   emode;
   } vec_t;

   typedef struct {
      logic [127:0] d;
      logic         l;
      logic [7:0]   m;
   } beat_t;

   vec_t  vecs[$];
   beat_t exp_q[$];

   function automatic logic [127:0] rep(input logic [7:0] b);
      return {16{b}};
   endfunction

   task automatic add(input logic rst_n, input logic treq, input logic [255:0] tdat,
                      input logic [7:0] cfg, input logic iack, input logic ereq,
                      input logic elast, input logic [127:0] edat, input logic chkdat,
                      input logic etack, input logic [7:0] emode);
      vec_t v;
      v.rst_n = rst_n; v.treq = treq; v.tdat = tdat; v.cfg = cfg; v.iack = iack;
      v.ereq = ereq; v.elast = elast; v.edat = edat; v.chkdat = chkdat;
      v.etack = etack; v.emode = emode;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [255:0] act,
                      input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   logic [127:0] A, B, U, C1, C2, C3, A2, B2, D3, D4, E, F, G, H0, H1, J0, J1;

   initial begin
      A  = rep(8'hAA); B  = rep(8'hBB); U  = rep(8'h55);
      C1 = rep(8'hC1); C2 = rep(8'hC2); C3 = rep(8'hC3);
      A2 = rep(8'hA2); B2 = rep(8'hB2); D3 = rep(8'hD3); D4 = rep(8'hD4);
      E  = rep(8'hEE); F  = rep(8'hFF); G  = rep(8'h99);
      H0 = rep(8'h10); H1 = rep(8'h11); J0 = rep(8'h20); J1 = rep(8'h21);

      // reset state
      add(0, 0, '0,          8'h00, 0,  0, 0, '0, 1, 0, 8'h00);
      // 2:1 single word
      add(1, 1, {B, A},      8'h01, 1,  0, 0, '0, 1, 1, 8'h00);
      add(1, 0, '0,          8'h01, 1,  1, 0, A,  1, 0, 8'h01);
      add(1, 0, '0,          8'h01, 1,  1, 1, B,  1, 1, 8'h01);
      add(1, 0, '0,          8'h00, 1,  0, 0, '0, 0, 1, 8'h01);
      // 1:1 three words back-to-back
      add(1, 1, {U, C1},     8'h00, 1,  0, 0, '0, 0, 1, 8'h01);
      add(1, 1, {U, C2},     8'h00, 1,  1, 1, C1, 1, 1, 8'h00);
      add(1, 1, {U, C3},     8'h00, 1,  1, 1, C2, 1, 1, 8'h00);
      add(1, 0, '0,          8'h00, 1,  1, 1, C3, 1, 1, 8'h00);
      add(1, 0, '0,          8'h00, 1,  0, 0, '0, 0, 1, 8'h00);
      // 2:1 with beat B stalled 4 cycles, next word waiting
      add(1, 1, {B2, A2},    8'h01, 1,  0, 0, '0, 0, 1, 8'h00);
      add(1, 1, {D4, D3},    8'h01, 1,  1, 0, A2, 1, 0, 8'h01);
      for (int k = 0; k < 4; k++)
         add(1, 1, {D4, D3}, 8'h01, 0,  1, 1, B2, 1, 0, 8'h01);
      add(1, 1, {D4, D3},    8'h01, 1,  1, 1, B2, 1, 1, 8'h01);
      add(1, 0, '0,          8'h00, 1,  1, 0, D3, 1, 0, 8'h01);
      add(1, 0, '0,          8'h00, 1,  1, 1, D4, 1, 1, 8'h01);
      add(1, 0, '0,          8'h00, 1,  0, 0, '0, 0, 1, 8'h01);
      // config flips 1->0 while a 2:1 word is held
      add(1, 1, {F, E},      8'h01, 1,  0, 0, '0, 0, 1, 8'h01);
      add(1, 1, {U, G},      8'h00, 1,  1, 0, E,  1, 0, 8'h01);
      add(1, 1, {U, G},      8'h00, 1,  1, 1, F,  1, 1, 8'h01);
      add(1, 0, '0,          8'h00, 1,  1, 1, G,  1, 1, 8'h00);
      add(1, 0, '0,          8'h00, 1,  0, 0, '0, 0, 1, 8'h00);
      // reset pulse while beat A is stalled
      add(1, 1, {H1, H0},    8'h81, 0,  0, 0, '0, 0, 1, 8'h00);
      add(1, 0, '0,          8'h00, 0,  1, 0, H0, 1, 0, 8'h81);
      add(0, 0, '0,          8'h00, 0,  1, 0, H0, 1, 0, 8'h81);
      add(1, 0, '0,          8'h00, 1,  0, 0, '0, 1, 1, 8'h00);
      add(1, 1, {J1, J0},    8'h01, 1,  0, 0, '0, 1, 1, 8'h00);
      add(1, 0, '0,          8'h00, 1,  1, 0, J0, 1, 0, 8'h01);
      add(1, 0, '0,          8'h00, 1,  1, 1, J1, 1, 1, 8'h01);
      add(1, 0, '0,          8'h00, 1,  0, 0, '0, 0, 1, 8'h01);

      reset_n = 1'b0; t_0_req = 1'b0; t_0_dat = '0; t_cfg_dat = '0; i_0_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         reset_n   = vecs[i].rst_n;
         t_0_req   = vecs[i].treq;
         t_0_dat   = vecs[i].tdat;
         t_cfg_dat = vecs[i].cfg;
         i_0_ack   = vecs[i].iack;
         @(negedge clk);
         chk("i_0_req",  i, {255'd0, i_0_req},  {255'd0, vecs[i].ereq});
         chk("i_0_last", i, {255'd0, i_0_last}, {255'd0, vecs[i].elast});
         chk("t_0_ack",  i, {255'd0, t_0_ack},  {255'd0, vecs[i].etack});
         chk("mode",     i, {248'd0, mode},     {248'd0, vecs[i].emode});
         if (vecs[i].chkdat)
            chk("i_0_dat", i, {128'd0, i_0_dat}, {128'd0, vecs[i].edat});
         @(posedge clk);
         #1;
      end

      // Randomized traffic: the model holds the beats still owed for the held word.
      exp_q.delete();
      for (int c = 0; c < 3000; c++) begin
         logic  exp_tack;
         beat_t bt;
         reset_n   = 1'b1;
         t_0_req   = ($urandom_range(0, 3) != 0);
         t_0_dat   = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
         t_cfg_dat = 8'($urandom);
         i_0_ack   = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         exp_tack = (exp_q.size() == 0) || (exp_q.size() == 1 && i_0_ack);
         chk("rnd_req",  c, {255'd0, i_0_req}, {255'd0, exp_q.size() != 0});
         chk("rnd_tack", c, {255'd0, t_0_ack}, {255'd0, exp_tack});
         if (exp_q.size() != 0) begin
            chk("rnd_dat",  c, {128'd0, i_0_dat},  {128'd0, exp_q[0].d});
            chk("rnd_last", c, {255'd0, i_0_last}, {255'd0, exp_q[0].l});
            chk("rnd_mode", c, {248'd0, mode},     {248'd0, exp_q[0].m});
            if (i_0_ack) void'(exp_q.pop_front());
         end
         if (t_0_req && exp_tack) begin
            bt.m = t_cfg_dat;
            bt.d = t_0_dat[127:0];
            bt.l = !t_cfg_dat[0];
            exp_q.push_back(bt);
            if (t_cfg_dat[0]) begin
               bt.d = t_0_dat[255:128];
               bt.l = 1'b1;
               exp_q.push_back(bt);
            end
         end
         @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
